// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit core: word width, the fetch-unit
// state encoding and a saturating counter helper.
package cpu16_pkg;

    localparam int WORD_W  = 16;
    localparam int ENTRY_W = 2 * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

    function automatic logic [WORD_W-1:0] sat_add(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b
    );
        logic [WORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WORD_W] ? '1 : sum[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage: DEPTH entries of {instr, pc}, one push and one
// pop per cycle, synchronous flush, registered head output.
// Ports: clock, reset (async, active-high), push/push_data, pop, flush,
//        count, head_valid, head_data (holds last value while empty).
module fetch_fifo
    import cpu16_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [CW-1:0]      count,
    output logic               head_valid,
    output logic [ENTRY_W-1:0] head_data
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_next;
    logic [CW-1:0]      count_next;
    logic               do_push;
    logic               do_pop;

    assign do_push    = push && !flush && (count != FULL);
    assign do_pop     = pop && !flush && (count != '0);
    assign rd_next    = rd_ptr + AW'(do_pop);
    assign count_next = count + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register is loaded from the slot that becomes the head.
    // When that slot is being written in the same cycle (queue empty after
    // the pop), the incoming data is forwarded instead of the stale slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_next;
            wr_ptr     <= wr_ptr + AW'(do_push);
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (count_next != '0) begin
                if (do_push && (wr_ptr == rd_next)) begin
                    head_data <= push_data;
                end else begin
                    head_data <= mem[rd_next];
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: issues one word request at a time, queues the
// returned words with their addresses and handles branch redirects.
// Ports: clock, reset (async, active-high); mem_req/mem_addr out,
//        mem_rvalid/mem_rdata in; redirect/redirect_pc in;
//        instr_valid/instr/instr_pc out, instr_ready in.
// Optional macro FETCH_STATS_EN adds stat_fetched and stat_dropped.
module instr_fetch_queue
    import cpu16_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
`ifdef FETCH_STATS_EN
    output logic [WORD_W-1:0] stat_fetched,
    output logic [WORD_W-1:0] stat_dropped,
`endif
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [WORD_W-1:0]  fetch_pc;
    logic [WORD_W-1:0]  req_addr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;
    logic               drop_rsp;
    logic [ENTRY_W-1:0] head_data;

    assign mem_addr = fetch_pc;
    assign pop      = instr_valid && instr_ready && !redirect;
    assign instr    = head_data[ENTRY_W-1:WORD_W];
    assign instr_pc = head_data[WORD_W-1:0];

    // With one request outstanding at most, issuing only while a slot is
    // free guarantees the response always fits.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        push       = 1'b0;
        drop_rsp   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset && !redirect && (count < FULL)) begin
                    mem_req    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    push       = !redirect;
                    drop_rsp   = redirect;
                    state_next = IDLE;
                end else if (redirect) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    drop_rsp   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
    // A redirect that coincides with the response in WAIT consumes that
    // response on the spot; waiting in DRAIN for it would never end.

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (mem_req) begin
                fetch_pc <= fetch_pc + 16'd1;
            end
            if (mem_req) begin
                req_addr <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  ({mem_rdata, req_addr}),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (instr_valid),
        .head_data  (head_data)
    );

`ifdef FETCH_STATS_EN
    logic [WORD_W-1:0] drop_amt;

    assign drop_amt = (redirect ? WORD_W'(count) : '0)
                    + WORD_W'(drop_rsp);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= sat_add(stat_fetched, WORD_W'(push));
            stat_dropped <= sat_add(stat_dropped, drop_amt);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a default instance plus a second
// instance with RESET_PC=16'hFFFF to exercise the address wrap.
module tb_instr_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    logic        mem_req2;
    logic [15:0] mem_addr2;
    logic        mem_rvalid2;
    logic [15:0] mem_rdata2;
    logic        instr_valid2;
    logic [15:0] instr2;
    logic [15:0] instr_pc2;

`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetched;
    logic [15:0] stat_dropped;
    logic [15:0] stat_fetched2;
    logic [15:0] stat_dropped2;
    logic [15:0] d0;
`endif

    logic auto_mem;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_req;

    always #5 clock = ~clock;

    instr_fetch_queue u_dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef FETCH_STATS_EN
        .stat_fetched(stat_fetched),
        .stat_dropped(stat_dropped),
`endif
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'hFFFF)
    ) u_wrap (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req2),
        .mem_addr    (mem_addr2),
        .mem_rvalid  (mem_rvalid2),
        .mem_rdata   (mem_rdata2),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
`ifdef FETCH_STATS_EN
        .stat_fetched(stat_fetched2),
        .stat_dropped(stat_dropped2),
`endif
        .instr_valid (instr_valid2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_ready (1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with a 1-cycle-latency memory: requests seen before the
    // edge are answered in the following cycle with data addr^16'h5A00.
    task automatic cyc();
        logic        p1;
        logic        p2;
        logic        am;
        logic [15:0] a1;
        logic [15:0] a2;
        @(negedge clock);
        p1 = mem_req;
        a1 = mem_addr;
        p2 = mem_req2;
        a2 = mem_addr2;
        am = auto_mem;
        @(posedge clock);
        #1;
        mem_rvalid  = p1 && am;
        mem_rdata   = (p1 && am) ? (a1 ^ 16'h5A00) : 16'h0000;
        mem_rvalid2 = p2;
        mem_rdata2  = a2;
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        auto_mem    = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 16'h0000;
        mem_rvalid2 = 1'b0;
        mem_rdata2  = 16'h0000;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        instr_ready = 1'b0;
        auto_mem    = 1'b1;
        cyc();
        cyc();
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);

        // streaming with ready=1
        instr_ready = 1'b1;
        reset       = 1'b0;
        #1;
        chk("t1_req0", mem_req, 1);
        chk("t1_addr0", mem_addr, 16'h0000);
        chk("wrap_addr0", mem_addr2, 16'hFFFF);
        cyc();
        chk("t1_wait_noreq", mem_req, 0);
        chk("t1_nobypass", instr_valid, 0);
        cyc();
        chk("wrap_req1", mem_req2, 1);
        chk("wrap_addr1", mem_addr2, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            chk("t1_valid", instr_valid, 1);
            chk("t1_pc", instr_pc, k);
            chk("t1_instr", instr, k ^ 16'h5A00);
            chk("t1_req", mem_req, 1);
            chk("t1_addr", mem_addr, k + 1);
            cyc();
            cyc();
        end

        // consumer stalled: queue fills after DEPTH requests
        do_reset();
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) n_req++;
            cyc();
        end
        chk("t2_nreq", n_req, 4);
        chk("t2_req_off", mem_req, 0);
        chk("t2_valid", instr_valid, 1);
        chk("t2_pc", instr_pc, 16'h0000);
        chk("t2_instr", instr, 16'h5A00);
`ifdef FETCH_STATS_EN
        chk("t2_fetched", stat_fetched, 4);
`endif

        // pop one, then redirect together with a pop at 3 entries
        instr_ready = 1'b1;
        #1;
        chk("t3_full_noreq", mem_req, 0);
        cyc();
        chk("t3_valid", instr_valid, 1);
        chk("t3_pc1", instr_pc, 16'h0001);
`ifdef FETCH_STATS_EN
        d0 = stat_dropped;
`endif
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        chk("t3_redir_noreq", mem_req, 0);
        cyc();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("t3_flushed", instr_valid, 0);
        chk("t3_req", mem_req, 1);
        chk("t3_addr", mem_addr, 16'h0100);
`ifdef FETCH_STATS_EN
        chk("t3_dropped", stat_dropped, d0 + 16'd3);
`endif
        cyc();
        cyc();
        chk("t3_new_valid", instr_valid, 1);
        chk("t3_new_pc", instr_pc, 16'h0100);
        chk("t3_new_instr", instr, 16'h5B00);

        // redirect while WAIT, late response must be discarded
        do_reset();
        instr_ready = 1'b1;
        auto_mem    = 1'b0;
        chk("t4_req0", mem_req, 1);
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        chk("t4_redir_noreq", mem_req, 0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("t4_drain_noreq", mem_req, 0);
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        #1;
        chk("t4_drop_noreq", mem_req, 0);
        cyc();
        chk("t4_req", mem_req, 1);
        chk("t4_addr", mem_addr, 16'h0040);
        chk("t4_novalid", instr_valid, 0);
        auto_mem = 1'b1;
        cyc();
        chk("t4_push_novalid", instr_valid, 0);
        cyc();
        chk("t4_valid", instr_valid, 1);
        chk("t4_pc", instr_pc, 16'h0040);
        chk("t4_instr", instr, 16'h5A40);
`ifdef FETCH_STATS_EN
        chk("t4_dropped", stat_dropped, 1);
        chk("t4_fetched", stat_fetched, 1);
`endif

        // reset asserted in WAIT
        do_reset();
        auto_mem = 1'b0;
        chk("t5_req0", mem_req, 1);
        cyc();
        reset = 1'b1;
        #1;
        chk("t5_rst_req", mem_req, 0);
        chk("t5_rst_valid", instr_valid, 0);
        cyc();
        cyc();
        chk("t5_rst_valid2", instr_valid, 0);
        reset = 1'b0;
        #1;
        chk("t5_req", mem_req, 1);
        chk("t5_addr", mem_addr, 16'h0000);
        chk("t5_valid", instr_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
